// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART core and its FIFOs.
package uart_pkg;

  // Ticks per serial bit and the tick index used to confirm a start bit.
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 7;

  // Common encoding for both the receive and transmit frame FSMs.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and registered flags.
// Handshake: push is accepted unless full (a push alongside a pop is accepted
// even when full); pop is accepted unless empty; each high cycle moves one word.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int NB_FIFO_ADDR = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [NB_DATA-1:0] wdata,
  input  logic               pop,
  output logic [NB_DATA-1:0] rdata,
  output logic               empty,
  output logic               full
);

  localparam int DEPTH = 2 ** NB_FIFO_ADDR;
  localparam logic [NB_FIFO_ADDR:0] FULL_CNT = (NB_FIFO_ADDR + 1)'(DEPTH);

  logic [NB_DATA-1:0]      mem [DEPTH];
  logic [NB_FIFO_ADDR-1:0] wr_ptr;
  logic [NB_FIFO_ADDR-1:0] rd_ptr;
  logic [NB_FIFO_ADDR:0]   count;
  logic [NB_FIFO_ADDR:0]   count_next;
  logic                    do_push;
  logic                    do_pop;

  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Head is visible as soon as the empty flag drops; zero while empty.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Occupancy after this cycle's accepted operations.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_CNT);
    end
  end

endmodule

// File: rtl/uart_serial_core.sv
// Full-duplex 8N1 UART: programmable baud tick, 16x oversampled receiver,
// transmitter, and a FIFO on each direction toward the CPU strobe interface.
module uart_serial_core
  import uart_pkg::*;
#(
  parameter int NB_COUNTER   = 9,
  parameter int NB_DATA      = 8,
  parameter int NB_FIFO_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic [NB_COUNTER-1:0] i_tick_cmp,
  input  logic                  i_wr,
  input  logic [NB_DATA-1:0]    i_wdata,
  input  logic                  i_tx_start,
  input  logic                  i_rd,
  output logic                  o_tx,
  output logic                  o_tx_done,
  output logic                  o_tx_empty,
  output logic                  o_tx_full,
  output logic [NB_DATA-1:0]    o_rdata,
  output logic                  o_rx_done,
  output logic                  o_rx_empty,
  output logic                  o_rx_full
);

  localparam int NB_BIT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [3:0]        LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]        MID_TICK  = 4'(SAMPLE_MID);
  localparam logic [NB_BIT-1:0] LAST_BIT  = NB_BIT'(NB_DATA - 1);

  // Baud generator
  logic [NB_COUNTER-1:0] baud_cnt;
  logic                  tick;

  assign tick = (baud_cnt == i_tick_cmp);

  // Free-running counter that wraps at the compare value, one tick per wrap.
  always_ff @(posedge clk) begin
    if (!i_rst) baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else baud_cnt <= baud_cnt + NB_COUNTER'(1);
  end

  // Receive path
  logic               rx_meta;
  logic               rx_sync;
  uart_state_t        rx_state;
  logic [3:0]         rx_tick_cnt;
  logic [NB_BIT-1:0]  rx_bit_cnt;
  logic [NB_DATA-1:0] rx_shreg;
  logic               rx_push;

  // Two-flop synchroniser; resets to the idle line level to avoid a false start.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive frame FSM: confirm start mid-bit, then sample every 16 ticks.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      rx_state    <= ST_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_shreg    <= '0;
      rx_push     <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (!rx_sync) begin
            rx_state    <= ST_START;
            rx_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_tick_cnt == MID_TICK) begin
              rx_tick_cnt <= '0;
              rx_bit_cnt  <= '0;
              rx_state    <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (rx_tick_cnt == LAST_TICK) begin
              rx_tick_cnt <= '0;
              rx_shreg    <= {rx_sync, rx_shreg[NB_DATA-1:1]};
              if (rx_bit_cnt == LAST_BIT) rx_state <= ST_STOP;
              else rx_bit_cnt <= rx_bit_cnt + 1'b1;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rx_tick_cnt == LAST_TICK) begin
              rx_tick_cnt <= '0;
              rx_state    <= ST_IDLE;
              // Framing errors and overflow both drop the byte silently.
              if (rx_sync && !o_rx_full) rx_push <= 1'b1;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 1'b1;
            end
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rx_done = rx_push;

  uart_sync_fifo #(
    .NB_DATA      (NB_DATA),
    .NB_FIFO_ADDR (NB_FIFO_ADDR)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (rx_push),
    .wdata (rx_shreg),
    .pop   (i_rd),
    .rdata (o_rdata),
    .empty (o_rx_empty),
    .full  (o_rx_full)
  );

  // Transmit path
  logic [NB_DATA-1:0] tx_head;
  uart_state_t        tx_state;
  logic [3:0]         tx_tick_cnt;
  logic [NB_BIT-1:0]  tx_bit_cnt;
  logic [NB_DATA-1:0] tx_shreg;
  logic               tx_pop;
  logic               tx_armed;
  logic               tx_out;
  logic               tx_done;

  // Transmit frame FSM plus arm flag. The FIFO pop is registered; the head is
  // captured at the same time, and the pointer moves long before the next load.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      tx_state    <= ST_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shreg    <= '0;
      tx_pop      <= 1'b0;
      tx_armed    <= 1'b0;
      tx_out      <= 1'b1;
      tx_done     <= 1'b0;
    end else begin
      tx_pop  <= 1'b0;
      tx_done <= 1'b0;
      if (i_tx_start) tx_armed <= 1'b1;
      case (tx_state)
        ST_IDLE: begin
          if (tx_armed && !o_tx_empty) begin
            tx_shreg    <= tx_head;
            tx_pop      <= 1'b1;
            tx_out      <= 1'b0;
            tx_tick_cnt <= '0;
            tx_state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tx_tick_cnt == LAST_TICK) begin
              tx_tick_cnt <= '0;
              tx_bit_cnt  <= '0;
              tx_out      <= tx_shreg[0];
              tx_state    <= ST_DATA;
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tx_tick_cnt == LAST_TICK) begin
              tx_tick_cnt <= '0;
              if (tx_bit_cnt == LAST_BIT) begin
                tx_out   <= 1'b1;
                tx_state <= ST_STOP;
              end else begin
                tx_bit_cnt <= tx_bit_cnt + 1'b1;
                tx_shreg   <= tx_shreg >> 1;
                tx_out     <= tx_shreg[1];
              end
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tx_tick_cnt == LAST_TICK) begin
              tx_tick_cnt <= '0;
              tx_done     <= 1'b1;
              if (tx_armed && !o_tx_empty) begin
                // Back-to-back frame: start bit follows the stop bit directly.
                tx_shreg <= tx_head;
                tx_pop   <= 1'b1;
                tx_out   <= 1'b0;
                tx_state <= ST_START;
              end else begin
                tx_state <= ST_IDLE;
              end
              if (o_tx_empty && !i_tx_start) tx_armed <= 1'b0;
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 1'b1;
            end
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx      = tx_out;
  assign o_tx_done = tx_done;

  uart_sync_fifo #(
    .NB_DATA      (NB_DATA),
    .NB_FIFO_ADDR (NB_FIFO_ADDR)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (i_rst),
    .push  (i_wr),
    .wdata (i_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (o_tx_empty),
    .full  (o_tx_full)
  );

endmodule

// File: tb/tb_uart_serial_core.sv
// Directed bench for uart_serial_core: a second instance receives the serial
// output so transmitted bytes can be read back through its RX FIFO.
module tb_uart_serial_core;

  localparam int NB_COUNTER   = 9;
  localparam int NB_DATA      = 8;
  localparam int NB_FIFO_ADDR = 4;
  localparam int BIT_CLK      = 32;  // 16 ticks per bit with i_tick_cmp = 1

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  rx = 1'b1;
  logic [NB_COUNTER-1:0] tick_cmp = 9'h146;
  logic                  wr = 1'b0;
  logic [NB_DATA-1:0]    wdata = '0;
  logic                  tx_start = 1'b0;
  logic                  rd = 1'b0;
  logic                  tx, tx_done, tx_empty, tx_full;
  logic [NB_DATA-1:0]    rdata;
  logic                  rx_done, rx_empty, rx_full;

  logic                  p_rd = 1'b0;
  logic                  p_tx, p_tx_done, p_tx_empty, p_tx_full;
  logic [NB_DATA-1:0]    p_rdata;
  logic                  p_rx_done, p_rx_empty, p_rx_full;

  uart_serial_core #(
    .NB_COUNTER(NB_COUNTER), .NB_DATA(NB_DATA), .NB_FIFO_ADDR(NB_FIFO_ADDR)
  ) dut (
    .clk(clk), .i_rst(rst), .i_rx(rx), .i_tick_cmp(tick_cmp),
    .i_wr(wr), .i_wdata(wdata), .i_tx_start(tx_start), .i_rd(rd),
    .o_tx(tx), .o_tx_done(tx_done), .o_tx_empty(tx_empty), .o_tx_full(tx_full),
    .o_rdata(rdata), .o_rx_done(rx_done), .o_rx_empty(rx_empty), .o_rx_full(rx_full)
  );

  uart_serial_core #(
    .NB_COUNTER(NB_COUNTER), .NB_DATA(NB_DATA), .NB_FIFO_ADDR(NB_FIFO_ADDR)
  ) peer (
    .clk(clk), .i_rst(rst), .i_rx(tx), .i_tick_cmp(tick_cmp),
    .i_wr(1'b0), .i_wdata(8'h00), .i_tx_start(1'b0), .i_rd(p_rd),
    .o_tx(p_tx), .o_tx_done(p_tx_done), .o_tx_empty(p_tx_empty), .o_tx_full(p_tx_full),
    .o_rdata(p_rdata), .o_rx_done(p_rx_done), .o_rx_empty(p_rx_empty), .o_rx_full(p_rx_full)
  );

  // Pulse counters
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int p_rx_done_cnt = 0;
  always @(posedge clk) begin
    if (tx_done)   tx_done_cnt++;
    if (rx_done)   rx_done_cnt++;
    if (p_rx_done) p_rx_done_cnt++;
  end

  // Scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [NB_DATA-1:0] exp_q[$];
  logic [NB_DATA-1:0] p_exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic write_byte(input logic [NB_DATA-1:0] d);
    wr = 1'b1; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse_start();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic send_frame(input logic [NB_DATA-1:0] d, input bit stop_ok);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < NB_DATA; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (24) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  // Compare the FIFO head with the scoreboard, then pop it.
  task automatic read_check(input bit use_peer, input string tag);
    logic [NB_DATA-1:0] e;
    if (use_peer) begin
      e = (p_exp_q.size() > 0) ? p_exp_q.pop_front() : '0;
      check_eq(tag, p_rdata, e);
      p_rd = 1'b1;
      @(negedge clk);
      p_rd = 1'b0;
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq(tag, rdata, e);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
  endtask

  task automatic wait_tx(input logic lvl, input int max, input string tag, output int cyc);
    cyc = 0;
    while (tx !== lvl && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    check_eq(tag, tx, lvl);
  endtask

  int base, base2, cyc, guard;
  logic [19:0] frame_bits;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_rx_done", rx_done, 0);
    check_eq("rst_tx_empty", tx_empty, 1);
    check_eq("rst_rx_empty", rx_empty, 1);
    check_eq("rst_tx_full", tx_full, 0);
    check_eq("rst_rx_full", rx_full, 0);
    check_eq("rst_rdata", rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Baud period at 0x146: bit 0 of 0x01 is high, bit 1 low -> one full bit
    write_byte(8'h01);
    write_byte(8'h02);
    pulse_start();
    wait_tx(1'b0, 400, "tick_start_fall", cyc);
    wait_tx(1'b1, 6000, "tick_bit0_rise", cyc);
    wait_tx(1'b0, 6000, "tick_bit1_fall", cyc);
    check_eq("tick_bit_clk", cyc, 5232);

    // Reset mid-frame: line idles, both FIFOs empty
    repeat (100) @(negedge clk);
    check_eq("pre_rst_tx_empty", tx_empty, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_tx", tx, 1);
    check_eq("midrst_tx_empty", tx_empty, 1);
    check_eq("midrst_rx_empty", rx_empty, 1);
    rst = 1'b1;
    tick_cmp = 9'd1;
    repeat (5) @(negedge clk);
    check_eq("midrst_idle_tx", tx, 1);

    // RX single byte
    base = rx_done_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("rx1_done_cnt", rx_done_cnt - base, 1);
    check_eq("rx1_not_empty", rx_empty, 0);
    read_check(1'b0, "rx1_data");
    check_eq("rx1_empty_after_rd", rx_empty, 1);

    // RX burst
    base = rx_done_cnt;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(8'h0B); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_frame(8'h0B, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("burst_done_cnt", rx_done_cnt - base, 4);
    for (int i = 0; i < 4; i++) read_check(1'b0, "burst_data");
    check_eq("burst_empty", rx_empty, 1);

    // RX overflow: 17 frames, no reads
    base = rx_done_cnt;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h40 + i), 1'b1);
      if (i < 16) exp_q.push_back(8'(8'h40 + i));
      if (i == 15) begin
        check_eq("ovf_full_at16", rx_full, 1);
        check_eq("ovf_cnt_at16", rx_done_cnt - base, 16);
      end
    end
    repeat (10) @(negedge clk);
    check_eq("ovf_cnt_at17", rx_done_cnt - base, 16);
    check_eq("ovf_still_full", rx_full, 1);
    for (int i = 0; i < 16; i++) read_check(1'b0, "ovf_data");
    check_eq("ovf_drained", rx_empty, 1);

    // Framing error
    base = rx_done_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check_eq("ferr_no_done", rx_done_cnt - base, 0);
    check_eq("ferr_empty", rx_empty, 1);

    // Start-bit glitch of 3 ticks
    base = rx_done_cnt;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    check_eq("glitch_no_done", rx_done_cnt - base, 0);
    check_eq("glitch_empty", rx_empty, 1);

    // TX loopback, two frames without a gap
    base  = tx_done_cnt;
    base2 = p_rx_done_cnt;
    p_exp_q.push_back(8'hA5);
    p_exp_q.push_back(8'h3C);
    write_byte(8'hA5);
    write_byte(8'h3C);
    pulse_start();
    wait_tx(1'b0, 100, "lb_start_fall", cyc);
    repeat (16) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      frame_bits[k] = tx;
      if (k < 19) repeat (BIT_CLK) @(negedge clk);
    end
    check_eq("lb_frame_a5", frame_bits[9:0], 10'h34A);
    check_eq("lb_frame_3c", frame_bits[19:10], 10'h278);
    repeat (40) @(negedge clk);
    check_eq("lb_tx_done_cnt", tx_done_cnt - base, 2);
    check_eq("lb_peer_done_cnt", p_rx_done_cnt - base2, 2);
    read_check(1'b1, "lb_peer_a5");
    read_check(1'b1, "lb_peer_3c");
    check_eq("lb_tx_empty", tx_empty, 1);
    check_eq("lb_tx_idle", tx, 1);

    // TX FIFO full, ignored 17th write, simultaneous write and pop when full
    for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
    check_eq("txf_full", tx_full, 1);
    write_byte(8'hEE);
    check_eq("txf_full_after_17", tx_full, 1);
    base = tx_done_cnt;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    @(negedge clk);
    wr = 1'b1; wdata = 8'h77;
    @(negedge clk);
    wr = 1'b0;
    check_eq("txf_full_wr_rd", tx_full, 1);
    for (int i = 0; i < 16; i++) p_exp_q.push_back(8'(8'h10 + i));
    p_exp_q.push_back(8'h77);
    guard = 0;
    while (tx_done_cnt - base < 8 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("txf_done_8", tx_done_cnt - base, 8);
    for (int i = 0; i < 8; i++) read_check(1'b1, "txf_peer_data");
    guard = 0;
    while (tx_done_cnt - base < 17 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("txf_done_17", tx_done_cnt - base, 17);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 9; i++) read_check(1'b1, "txf_peer_data");
    check_eq("txf_peer_empty", p_rx_empty, 1);
    check_eq("txf_tx_empty", tx_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
